// File: rtl/smac_seq_ctrl.sv
// rtl/smac_seq_ctrl.sv - bit-serial MAC sequencer: operand load, AC2 clear, Pw shift cycles, result handshake
module smac_seq_ctrl #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int Pw = 4,
  parameter int LW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LW-1:0]           cfg_len,
  input  logic                    abort,
  input  logic                    stall,
  input  logic                    op_valid,
  output logic                    op_ready,
  output logic                    ld_en,
  output logic                    cl_en,
  output logic                    w_and_s,
  output logic [$clog2(Pw)-1:0]   bit_idx,
  output logic                    msb_sub,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [LW-1:0]           vec_cnt,
  output logic                    busy,
  output logic                    done
);

  localparam int BW = $clog2(Pw);

  if (M < 1 || Pa < 1 || Pw < 2) begin : g_bad_param
    $error("smac_seq_ctrl: M, Pa must be >= 1 and Pw >= 2");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [LW-1:0]   vec_cnt_q;
  logic [LW-1:0]   len_q;
  logic            done_q;
  logic            last_bit;
  logic            abort_act;
  logic            shift_act;

  assign last_bit  = (bit_cnt_q == BW'(Pw - 1));
  assign abort_act = abort && (state_q != IDLE);
  // abort outranks every strobe so a discarded dot product never touches AC2
  assign shift_act = (state_q == SHIFT) && !stall && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      vec_cnt_q <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_act) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        vec_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (cfg_len != '0) begin
                len_q     <= cfg_len;
                vec_cnt_q <= '0;
                state_q   <= LOAD;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (op_valid) begin
              bit_cnt_q <= '0;
              state_q   <= SHIFT;
            end
          end
          SHIFT: begin
            if (!stall) begin
              if (last_bit) begin
                bit_cnt_q <= '0;
                state_q   <= DONE;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          DONE: begin
            if (res_ready) begin
              if (vec_cnt_q == len_q - LW'(1)) begin
                vec_cnt_q <= '0;
                done_q    <= 1'b1;
                state_q   <= IDLE;
              end else begin
                vec_cnt_q <= vec_cnt_q + 1'b1;
                state_q   <= LOAD;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign op_ready  = (state_q == LOAD) && !abort;
  assign ld_en     = (state_q == LOAD) && op_valid && !abort;
  assign cl_en     = ld_en || abort_act;
  assign w_and_s   = shift_act;
  assign msb_sub   = shift_act && last_bit;
  assign bit_idx   = (state_q == SHIFT) ? bit_cnt_q : '0;
  assign res_valid = (state_q == DONE);
  assign vec_cnt   = vec_cnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// tb/tb_smac_seq_ctrl.sv - directed self-checking bench for smac_seq_ctrl (Pw=4)
module tb_smac_seq_ctrl;

  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] cfg_len;
  logic          abort;
  logic          stall;
  logic          op_valid;
  logic          op_ready;
  logic          ld_en;
  logic          cl_en;
  logic          w_and_s;
  logic [1:0]    bit_idx;
  logic          msb_sub;
  logic          res_valid;
  logic          res_ready;
  logic [LW-1:0] vec_cnt;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  smac_seq_ctrl #(.M(16), .Pa(8), .Pw(4), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .abort(abort),
    .stall(stall), .op_valid(op_valid), .op_ready(op_ready), .ld_en(ld_en),
    .cl_en(cl_en), .w_and_s(w_and_s), .bit_idx(bit_idx), .msb_sub(msb_sub),
    .res_valid(res_valid), .res_ready(res_ready), .vec_cnt(vec_cnt),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int shifts, dones, rvs, vexp, wcnt, msbs;

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; abort = 1'b0; stall = 1'b0;
    op_valid = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_cl_en", cl_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single dot product, no stall/backpressure
    tick(); start = 1'b1; cfg_len = 8'd1; op_valid = 1'b1; res_ready = 1'b1;
    tick(); start = 1'b0; settle();
    chk("t1_ld_en", ld_en, 1);
    chk("t1_cl_en", cl_en, 1);
    chk("t1_op_ready", op_ready, 1);
    chk("t1_w_and_s_c1", w_and_s, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      chk("t1_w_and_s", w_and_s, 1);
      chk("t1_bit_idx", bit_idx, i);
      chk("t1_msb_sub", msb_sub, (i == 3) ? 1 : 0);
      chk("t1_ld_en_shift", ld_en, 0);
    end
    tick(); settle();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_w_and_s_done", w_and_s, 0);
    chk("t1_done_early", done, 0);
    tick(); settle();
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    tick(); settle();
    chk("t1_done_pulse", done, 0);
    op_valid = 1'b0; res_ready = 1'b0;

    // three vectors, 5 cycles of backpressure at each DONE, start while busy ignored
    tick(); start = 1'b1; cfg_len = 8'd3; op_valid = 1'b1;
    shifts = 0; dones = 0; rvs = 0; vexp = 0; wcnt = 0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      start = (c == 10);
      cfg_len = (c == 1) ? 8'd3 : 8'd7;
      res_ready = 1'b0;
      settle();
      if (w_and_s) shifts++;
      if (done) dones++;
      if (res_valid) begin
        rvs++;
        wcnt++;
        if (wcnt == 1) begin
          chk("t2_vec_cnt", vec_cnt, vexp);
          vexp++;
        end
        if (wcnt == 6) begin
          res_ready = 1'b1;
          wcnt = 0;
        end
      end
    end
    start = 1'b0;
    chk("t2_shift_cycles", shifts, 12);
    chk("t2_done_pulses", dones, 1);
    chk("t2_res_valid_cycles", rvs, 18);
    chk("t2_vectors", vexp, 3);
    chk("t2_busy_end", busy, 0);
    op_valid = 1'b0; res_ready = 1'b0;

    // stall for 3 cycles at bit 2
    tick(); start = 1'b1; cfg_len = 8'd1; op_valid = 1'b1; res_ready = 1'b1;
    shifts = 0; msbs = 0; dones = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      stall = (c >= 4 && c <= 6);
      settle();
      if (w_and_s) shifts++;
      if (msb_sub) msbs++;
      if (done) dones++;
      if (stall) begin
        chk("t3_stall_w_and_s", w_and_s, 0);
        chk("t3_stall_bit_idx", bit_idx, 2);
        chk("t3_stall_msb", msb_sub, 0);
      end
      if (c == 8) chk("t3_msb_at_bit3", msb_sub, 1);
      if (c == 9) chk("t3_res_valid", res_valid, 1);
    end
    stall = 1'b0;
    chk("t3_shift_cycles", shifts, 4);
    chk("t3_msb_cycles", msbs, 1);
    chk("t3_done_pulses", dones, 1);
    op_valid = 1'b0; res_ready = 1'b0;

    // operand not available for 4 cycles in LOAD
    tick(); start = 1'b1; cfg_len = 8'd1; res_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(); start = 1'b0; settle();
      chk("t4_op_ready", op_ready, 1);
      chk("t4_ld_en", ld_en, 0);
      chk("t4_cl_en", cl_en, 0);
      chk("t4_w_and_s", w_and_s, 0);
    end
    tick(); op_valid = 1'b1; settle();
    chk("t4_ld_en_rise", ld_en, 1);
    tick(); settle();
    chk("t4_first_shift", w_and_s, 1);
    chk("t4_first_bit", bit_idx, 0);
    for (int c = 0; c < 20 && busy; c++) tick();
    chk("t4_finished", busy, 0);
    op_valid = 1'b0; res_ready = 1'b0;

    // zero-length job
    tick(); start = 1'b1; cfg_len = 8'd0;
    settle();
    tick(); start = 1'b0; settle();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 1);
    tick(); settle();
    chk("t5_done_pulse", done, 0);
    chk("t5_busy_after", busy, 0);

    // abort during SHIFT
    tick(); start = 1'b1; cfg_len = 8'd2; op_valid = 1'b1; res_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); abort = 1'b1; settle();
    chk("t6_abort_cl_en", cl_en, 1);
    chk("t6_abort_w_and_s", w_and_s, 0);
    tick(); abort = 1'b0; op_valid = 1'b0; settle();
    chk("t6_idle", busy, 0);
    chk("t6_cl_en_off", cl_en, 0);
    chk("t6_vec_cnt", vec_cnt, 0);
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) dones++;
      tick();
    end
    chk("t6_no_done", dones, 0);

    // reset asserted while a result is waiting in DONE
    tick(); start = 1'b1; cfg_len = 8'd2; op_valid = 1'b1; res_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick(); start = 1'b0;
    end
    settle();
    chk("t7_res_valid_pre", res_valid, 1);
    rst_n = 1'b0; settle();
    chk("t7_rst_res_valid", res_valid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_op_ready", op_ready, 0);
    chk("t7_rst_ld_en", ld_en, 0);
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); settle();
    chk("t7_after_busy", busy, 0);
    chk("t7_after_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smac_seq_ctrl.md
Name: smac_seq_ctrl

Overview:
- Sequencer for the bit-serial MAC datapath: operand input registers, AC1 adder stage, and the AC2 shift-accumulate register.
- Per job, processes cfg_len dot products. For each one it loads operands, clears AC2, then issues Pw weight-bit shift cycles, LSB first, with MSB subtraction for two's complement.
- Presents each result with a valid/ready handshake and holds AC2 until the result is consumed.
- Sits between the operand buffer/job controller and the MAC datapath.

Parameters:
- M, 16, activations per dot product (pass-through for datapath sizing only)
- Pa, 8, activation width (pass-through only)
- Pw, 4, weight width = shift cycles per dot product; must be ≥2
- LW, 8, width of cfg_len and vec_cnt

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- cfg_len  in  LW  dot products in the job; latched on accepted start
- abort  in  1  synchronous job abort
- stall  in  1  freezes SHIFT progress
- op_valid  in  1  operand beat available
- op_ready  out  1  controller accepts operand beat
- ld_en  out  1  load operand registers
- cl_en  out  1  clear AC2
- w_and_s  out  1  AC2 shift-accumulate enable
- bit_idx  out  $clog2(Pw)  weight bit selected for AC1
- msb_sub  out  1  current bit is sign bit; AC1 negates
- res_valid  out  1  AC2 holds a finished result
- res_ready  in  1  result consumer ready
- vec_cnt  out  LW  index of current dot product
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bit_cnt=0; vec_cnt=0; len_q=0. All outputs are 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1, cfg_len≠0: latch len_q, vec_cnt=0, next LOAD.
  - start=1, cfg_len=0: done=1 on the next cycle; remain IDLE.
  - start in any other state is ignored.
- LOAD:
  - op_ready=1.
  - ld_en = cl_en = op_valid (combinational, same cycle).
  - On op_valid: bit_cnt=0, next SHIFT. Otherwise hold in LOAD.
- SHIFT:
  - w_and_s = !stall.
  - bit_idx = bit_cnt; msb_sub = (bit_cnt==Pw-1) & !stall.
  - bit_cnt increments only when !stall.
  - Shift cycle with bit_cnt==Pw-1 and !stall: next DONE, bit_cnt=0.
  - Exactly Pw asserted w_and_s cycles per dot product, never more.
- DONE:
  - res_valid=1; w_and_s=0 (AC2 frozen).
  - res_valid stays high until res_ready, regardless of res_ready history.
  - On res_ready and vec_cnt==len_q-1: next IDLE, done=1 next cycle, vec_cnt=0.
  - On res_ready otherwise: vec_cnt+1, next LOAD.
- Latency, no stall/backpressure: op accept to res_valid = Pw+1 cycles. Per-vector period = Pw+2 cycles.
- abort, any non-IDLE state:
  - Next state IDLE; cl_en=1 for one cycle; counters cleared; no done pulse.
  - abort has priority over all other transitions.
- abort in IDLE: no effect.
- stall outside SHIFT: no effect.
- Reset mid-operation: immediate return to the reset values above; any partial result is discarded.
- cfg_len changes after latch: no effect until the next job.

Test Plan:
- Pw=4, start with cfg_len=1, op_valid=1, res_ready=1:
  - ld_en/cl_en in cycle 1; w_and_s in cycles 2-5 with bit_idx 0,1,2,3; msb_sub only in cycle 5.
  - res_valid in cycle 6; done in cycle 7.
- cfg_len=3, res_ready low for 5 cycles at each DONE:
  - res_valid held steady; exactly 12 w_and_s cycles total; vec_cnt steps 0,1,2; single done pulse.
- stall=1 for 3 cycles at bit_cnt=2:
  - w_and_s=0 and bit_idx=2 held throughout; still exactly 4 shift cycles; msb_sub only at bit 3.
- op_valid low for 4 cycles in LOAD:
  - op_ready stays high; ld_en=0, cl_en=0; no shift until op_valid rises.
- start with cfg_len=0 → busy never asserts; done pulses once one cycle later.
- Mid-job events:
  - abort during SHIFT → cl_en pulse, IDLE next cycle, no done.
  - rst_n low during DONE → all outputs 0 immediately.
  - start while busy → ignored; job continues unchanged.
